// File: rtl/nibble_add_seq.sv
// nibble_add_seq: WIDTH-bit add/subtract computed one nibble per clock through a
// single shared 4-bit ripple slice, with valid/ready handshakes on both sides.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       g,
    output logic       p
);
    logic [4:0] c;
    logic [3:0] gi, pi;
    always_comb begin
        gi = a & b;
        pi = a ^ b;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) c[i+1] = gi[i] | (pi[i] & c[i]);
        s = pi ^ c[3:0];
        c_out = c[4];
        g = gi[3] | (pi[3] & gi[2]) | (&pi[3:2] & gi[1]) | (&pi[3:1] & gi[0]);
        p = &pi;
    end
endmodule

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW = $clog2(NSLICE);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic carry_r;
    logic [KW-1:0] k;
    logic [3:0] s;
    logic c_out, last, unused_g, unused_p;

    assign last = k == KW'(NSLICE - 1);

    four_bit_adder slice (
        .a(a_r[4*k +: 4]),
        .b(b_r[4*k +: 4]),
        .c_in(carry_r),
        .s(s),
        .c_out(c_out),
        .g(unused_g),
        .p(unused_p)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE && in_valid) ? RUN :
                   (state == RUN && last) ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    assign in_ready = state == IDLE;
    assign busy = state == RUN;
    assign out_valid = state == DONE;

    // Subtraction is A + ~B + 1, with cin acting as a borrow that cancels the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            carry_r <= 1'b0;
            k <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            k <= '0;
        end else if (state == RUN) begin
            sum[4*k +: 4] <= s;
            carry_r <= c_out;
            k <= k + KW'(1);
            if (last) begin
                cout <= c_out;
                ovf <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ s[3] ^ c_out;
            end
        end
    end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle wide adder/subtractor that shares one 4-bit ripple slice (`four_bit_adder`) across all nibbles of a WIDTH-bit operand pair. It processes one nibble per clock, LSB first, and holds the carry in a register between nibbles. Operands enter and results leave through valid/ready handshakes. The block sits between the accumulation datapath and the arithmetic slice, and trades throughput for area.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and ≥ 8.
- `NSLICE`, derived, = WIDTH/4: number of nibble steps per operation.

- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — operand request.
- `in_ready`  out  1  — block can accept operands.
- `a`  in  WIDTH  — operand A.
- `b`  in  WIDTH  — operand B.
- `sub`  in  1  — 1 = compute A − B, 0 = compute A + B.
- `cin`  in  1  — carry-in for add; borrow-in for sub.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — consumer accepts the result.
- `sum`  out  WIDTH  — registered result.
- `cout`  out  1  — raw carry out of the MSB. For sub, 1 = no borrow.
- `ovf`  out  1  — two's-complement overflow.
- `busy`  out  1  — high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `a_r`=`a`, `b_r`=`sub`?~`b`:`b`, `carry_r`=`cin`^`sub`.
  - Clear the slice index `k` to 0; go to RUN.
- **RUN**
  - Each cycle, drive the slice with `a_r[4k+3:4k]`, `b_r[4k+3:4k]` and `carry_r`.
  - On the clock edge: write the slice S into `sum[4k+3:4k]`, set `carry_r`=C_OUT, increment `k`.
  - On the edge where `k`=NSLICE−1:
    - `cout`=C_OUT of that step.
    - `ovf`=(`a_r`[MSB]^`b_r`[MSB]^S[3])^C_OUT, i.e. carry into MSB xor carry out of MSB.
    - Go to DONE.
- **DONE**
  - `out_valid`=1.
  - `sum`, `cout` and `ovf` stay stable until `out_valid`&&`out_ready`.
  - On that edge, go to IDLE.
- `in_ready` = (state==IDLE) and `busy` = (state==RUN). Both are decoded from the registered state with no combinational path from inputs.
- `in_valid` outside IDLE is ignored. Operands are sampled only at the accept edge, so later changes to `a`, `b`, `sub` or `cin` have no effect.
- The slice's G/P outputs are unused.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- During RUN, `sum` updates one nibble per cycle. Its contents are defined only while `out_valid`=1.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n`=0):
  - State=IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - `carry_r`, `k`, `a_r`, `b_r` = 0.
- **Latency:** accept edge T0. `out_valid` rises after edge T0+NSLICE (4 clocks for WIDTH=16).
- **Throughput:** at best one operation per NSLICE+2 clocks (accept edge, NSLICE RUN edges, output edge). Back-to-back accept is not supported; `in_ready` rises the cycle after the output handshake.
- **Backpressure:** DONE is held indefinitely while `out_ready`=0 and outputs do not change.
- **`out_ready` outside DONE:** ignored.
- **Reset mid-RUN or mid-DONE:** the operation is abandoned and all outputs go to reset values. A new request is accepted on the first edge after `rst_n` rises.
- **WIDTH boundary:** the top nibble uses the same slice. Overflow is computed from bit WIDTH−1 only.

## Test plan
1. **Basic add, latency.** WIDTH=16: a=0x1234, b=0x4321, sub=0, cin=0.
   - Expect `sum`=0x5555, `cout`=0, `ovf`=0.
   - `out_valid` rises exactly 4 clocks after the accept edge; `busy` is high for 4 cycles.
2. **Carry chain.**
   - 0xFFFF+0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0.
   - 0x7FFF+0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
   - 0x0000+0x0000, cin=1 → `sum`=0x0001.
3. **Subtract.**
   - 0x0005−0x0007, cin=0 → `sum`=0xFFFE, `cout`=0, `ovf`=0.
   - 0x8000−0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
   - 0x0010−0x0001, cin=1 (borrow) → `sum`=0x000E.
4. **Backpressure and ignored request.** Hold `out_ready`=0 for 5 cycles after `out_valid` while toggling `a`/`b` and holding `in_valid`=1.
   - `sum`/`cout`/`ovf` stay stable and `in_ready`=0 throughout.
   - After `out_ready`=1: one cycle of IDLE, then the pending request is accepted.
5. **Reset mid-RUN.** Assert `rst_n`=0 after 2 RUN edges of 0xABCD+0x1111.
   - All outputs go to 0 immediately and `in_ready`=1.
   - Next op 0x0F0F+0x00F1 → `sum`=0x1000, `cout`=0.
6. **Random regression.** 1000 random a/b/sub/cin with random `out_ready` stalls, WIDTH=16 and WIDTH=32.
   - Results match the golden model: modulo sum, carry, overflow.
   - Each accepted request produces exactly one output handshake.
